cache_refill_ctrl: RTL and testbench

//  Miss/refill and write-through controller sitting between the memory-stage cache and main memory.
//  On a load (lbu) miss it stalls the pipeline, fetches the word from memory, and writes the selected

---
 rtl/cache_refill_ctrl.sv | 109 ++++++++++
 tb/tb_cache_refill_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: lbu miss refill and sb write-through controller between the M-stage cache and memory,
// with saturating load/miss counters.
module cache_refill_ctrl #(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              LdSrcM,
    input  logic              StSrcM,
    input  logic [ADDR_W-1:0] addrM,
    input  logic [31:0]       storeDataM,
    input  logic              cacheHit,
    output logic              stall,
    output logic              cacheWE,
    output logic              cacheStSrc,
    output logic [ADDR_W-1:0] cacheAddr,
    output logic [31:0]       cacheData,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWData,
    output logic [3:0]        memBe,
    input  logic              memAck,
    input  logic [31:0]       memRData,
    output logic [CNT_W-1:0]  loadCnt,
    output logic [CNT_W-1:0]  missCnt
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] FILL    = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        byte_q, byte_d;
    logic [CNT_W-1:0]  loadCnt_q, loadCnt_d, missCnt_q, missCnt_d;
    logic              idle, st_go, fill, rd, wr;
    logic              unused_ok;

    assign unused_ok = ^storeDataM[31:8];
    assign idle  = state_q == IDLE;
    assign st_go = idle && StSrcM;
    assign fill  = state_q == FILL;
    assign rd    = state_q == RD_WAIT;
    assign wr    = state_q == WR_WAIT;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        byte_d    = byte_q;
        loadCnt_d = loadCnt_q;
        missCnt_d = missCnt_q;
        case (state_q)
            IDLE: begin
                if (StSrcM) begin
                    state_d = WR_WAIT;
                    addr_d  = addrM;
                    byte_d  = storeDataM[7:0];
                end else if (LdSrcM) begin
                    loadCnt_d = &loadCnt_q ? loadCnt_q : loadCnt_q + 1'b1;
                    if (!cacheHit) begin
                        state_d   = RD_WAIT;
                        addr_d    = addrM;
                        missCnt_d = &missCnt_q ? missCnt_q : missCnt_q + 1'b1;
                    end
                end
            end
            RD_WAIT: if (memAck) begin
                byte_d  = memRData[{addr_q[1:0], 3'b000} +: 8];
                state_d = FILL;
            end
            FILL:    state_d = DONE;
            WR_WAIT: if (memAck) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            byte_q    <= '0;
            loadCnt_q <= '0;
            missCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            byte_q    <= byte_d;
            loadCnt_q <= loadCnt_d;
            missCnt_q <= missCnt_d;
        end
    end

    // DONE deliberately drops stall so the held instruction retires before a new request is taken
    assign stall      = rd || fill || wr || (idle && (StSrcM || (LdSrcM && !cacheHit)));
    assign cacheWE    = st_go || fill;
    assign cacheStSrc = cacheWE;
    assign cacheAddr  = st_go ? addrM : fill ? addr_q : '0;
    assign cacheData  = {24'b0, st_go ? storeDataM[7:0] : fill ? byte_q : 8'h00};
    assign memReq     = rd || wr;
    assign memWe      = wr;
    assign memAddr    = memReq ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign memWData   = wr ? {4{byte_q}} : 32'h0;
    assign memBe      = wr ? 4'b0001 << addr_q[1:0] : 4'b0000;
    assign loadCnt    = loadCnt_q;
    assign missCnt    = missCnt_q;
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: randomized transactions checked cycle by cycle against a transaction-level model;
// a second 4-bit-counter instance shares the inputs to exercise counter saturation.
module tb_cache_refill_ctrl;
    logic        clk = 0, rst_n = 0, LdSrcM = 0, StSrcM = 0, cacheHit = 0, memAck = 0;
    logic [31:0] addrM = 0, storeDataM = 0, memRData = 0;
    logic        stall, cacheWE, cacheStSrc, memReq, memWe;
    logic [31:0] cacheAddr, cacheData, memAddr, memWData, loadCnt, missCnt;
    logic [3:0]  memBe;
    logic        stall_s, cacheWE_s, cacheStSrc_s, memReq_s, memWe_s;
    logic [31:0] cacheAddr_s, cacheData_s, memAddr_s, memWData_s;
    logic [3:0]  memBe_s, loadCnt_s, missCnt_s;
    int          checks = 0, errors = 0;
    longint      n_ld = 0, n_ms = 0;

    always #5 clk = ~clk;

    cache_refill_ctrl dut (
        .clk(clk), .rst_n(rst_n), .LdSrcM(LdSrcM), .StSrcM(StSrcM), .addrM(addrM),
        .storeDataM(storeDataM), .cacheHit(cacheHit), .stall(stall), .cacheWE(cacheWE),
        .cacheStSrc(cacheStSrc), .cacheAddr(cacheAddr), .cacheData(cacheData), .memReq(memReq),
        .memWe(memWe), .memAddr(memAddr), .memWData(memWData), .memBe(memBe), .memAck(memAck),
        .memRData(memRData), .loadCnt(loadCnt), .missCnt(missCnt)
    );

    cache_refill_ctrl #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .LdSrcM(LdSrcM), .StSrcM(StSrcM), .addrM(addrM),
        .storeDataM(storeDataM), .cacheHit(cacheHit), .stall(stall_s), .cacheWE(cacheWE_s),
        .cacheStSrc(cacheStSrc_s), .cacheAddr(cacheAddr_s), .cacheData(cacheData_s), .memReq(memReq_s),
        .memWe(memWe_s), .memAddr(memAddr_s), .memWData(memWData_s), .memBe(memBe_s), .memAck(memAck),
        .memRData(memRData), .loadCnt(loadCnt_s), .missCnt(missCnt_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint n, input int w);
        longint m;
        m = (64'sd1 <<< w) - 1;
        return n > m ? m : n;
    endfunction

    task automatic outs(input string tag, input logic st, input logic cwe, input logic [31:0] ca,
                        input logic [31:0] cd, input logic mr, input logic mw, input logic [31:0] ma,
                        input logic [31:0] md, input logic [3:0] be);
        check({tag, ".stall"}, stall, st);
        check({tag, ".cacheWE"}, cacheWE, cwe);
        check({tag, ".cacheStSrc"}, cacheStSrc, cwe);
        check({tag, ".cacheAddr"}, cacheAddr, ca);
        check({tag, ".cacheData"}, cacheData, cd);
        check({tag, ".memReq"}, memReq, mr);
        check({tag, ".memWe"}, memWe, mw);
        check({tag, ".memAddr"}, memAddr, ma);
        check({tag, ".memWData"}, memWData, md);
        check({tag, ".memBe"}, memBe, be);
    endtask

    task automatic cnts(input string tag);
        check({tag, ".loadCnt"}, loadCnt, sat(n_ld, 32));
        check({tag, ".missCnt"}, missCnt, sat(n_ms, 32));
        check({tag, ".loadCnt4"}, loadCnt_s, sat(n_ld, 4));
        check({tag, ".missCnt4"}, missCnt_s, sat(n_ms, 4));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle;
        memAck = 1'($urandom);
        memRData = $urandom;
        @(negedge clk);
        outs("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        memAck = 0;
    endtask

    task automatic load_hit(input logic [31:0] a);
        LdSrcM = 1; cacheHit = 1; addrM = a;
        @(negedge clk);
        outs("hit", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        n_ld++;
        cnts("hit");
        LdSrcM = 0; cacheHit = 0;
    endtask

    task automatic load_miss(input logic [31:0] a, input logic [31:0] rdata, input int w);
        logic [7:0]  b;
        logic [31:0] wa;
        b  = 8'(rdata >> (8 * a[1:0]));
        wa = {a[31:2], 2'b00};
        LdSrcM = 1; cacheHit = 0; addrM = a; memAck = 0;
        @(negedge clk);
        outs("miss.idle", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        n_ld++; n_ms++;
        cnts("miss.idle");
        addrM = $urandom;
        for (int i = 0; i <= w; i++) begin
            memAck = (i == w);
            memRData = (i == w) ? rdata : $urandom;
            @(negedge clk);
            outs("miss.rd", 1, 0, 0, 0, 1, 0, wa, 0, 0);
            tick;
        end
        memAck = 1'($urandom);
        memRData = $urandom;
        @(negedge clk);
        outs("miss.fill", 1, 1, a, {24'b0, b}, 0, 0, 0, 0, 0);
        tick;
        @(negedge clk);
        outs("miss.done", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        cnts("miss.done");
        LdSrcM = 0; memAck = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input int w);
        logic [7:0] b;
        b = d[7:0];
        StSrcM = 1; LdSrcM = 1'($urandom); cacheHit = 1'($urandom); addrM = a; storeDataM = d; memAck = 0;
        @(negedge clk);
        outs("st.idle", 1, 1, a, {24'b0, b}, 0, 0, 0, 0, 0);
        tick;
        cnts("st.idle");
        addrM = $urandom; storeDataM = $urandom;
        for (int i = 0; i <= w; i++) begin
            memAck = (i == w);
            @(negedge clk);
            outs("st.wr", 1, 0, 0, 0, 1, 1, {a[31:2], 2'b00}, {4{b}}, 4'b0001 << a[1:0]);
            tick;
        end
        memAck = 1'($urandom);
        @(negedge clk);
        outs("st.done", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        cnts("st.done");
        StSrcM = 0; LdSrcM = 0; memAck = 0;
    endtask

    initial begin
        memAck = 1;
        tick;
        tick;
        @(negedge clk);
        outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cnts("reset");
        rst_n = 1; memAck = 0;
        tick;

        load_hit(32'h100);
        load_miss(32'h106, 32'hAABBCCDD, 2);
        store(32'h203, 32'h12345678, 0);

        LdSrcM = 1; cacheHit = 0; addrM = 32'h0000_0040;
        tick;
        @(negedge clk);
        check("midrst.memReq_before", memReq, 1);
        rst_n = 0; LdSrcM = 0;
        tick;
        n_ld = 0; n_ms = 0;
        @(negedge clk);
        check("midrst.memReq_after", memReq, 0);
        cnts("midrst");
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            memAck = 1; memRData = $urandom;
            @(negedge clk);
            outs("midrst.lateack", 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick;
        end
        memAck = 0;
        load_hit(32'h44);

        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 3))
                0: idle_cycle;
                1: load_hit($urandom);
                2: load_miss($urandom, $urandom, $urandom_range(0, 3));
                default: store($urandom, $urandom, $urandom_range(0, 3));
            endcase
        end
        for (int i = 0; i < 20; i++) load_miss($urandom, $urandom, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
